mem_bank_atomic_sram: RTL and testbench
=======================================

// Module: mem_bank_atomic_sram
// PURPOSE
//  Single-bank memory endpoint that consumes one bank lane of the interleaved AXI-to-memory
//  request stream (req/gnt, addr, wdata, strb, we, atop) and answers with rvalid/rdata.
//  Holds NumWords x DataWidth storage, has fixed read latency and executes AXI5 ATOPs as
//  in-bank read-modify-write. Instantiated once per bank, directly below the bank arbiter.
// PARAMETERS
//  AddrWidth  32   byte-address width of mem_addr_i
//  DataWidth  32   bank word width in bits, multiple of 8, >= 8
//  NumWords   1024 words in bank, power of two, >= 2
//  Latency    1    grant-to-rvalid cycles, >= 1
// PORTS
//  clk_i          in   1               clock, all state on rising edge
//  rst_ni         in   1               asynchronous reset, active low
//  mem_req_i      in   1               request valid
//  mem_gnt_o      out  1               request accepted this cycle (req & gnt = handshake)
//  mem_addr_i     in   AddrWidth       byte address
//  mem_wdata_i    in   DataWidth       write data / ATOP operand
//  mem_strb_i     in   DataWidth/8     byte enables for writes and ATOP writeback
//  mem_atop_i     in   6               axi_pkg::atop_t
//  mem_we_i       in   1               write enable
//  mem_rvalid_o   out  1               one response per handshake, no backpressure
//  mem_rdata_o    out  DataWidth       response data
// BEHAVIOUR
//  - Word index = mem_addr_i[$clog2(DataWidth/8) +: $clog2(NumWords)]; other addr bits ignored.
//  - Reset: state IDLE, response pipeline valid bits 0, mem_rvalid_o=0, mem_rdata_o='0,
//    mem_gnt_o=0 during reset. Storage contents are not reset. Reset mid-operation drops
//    all in-flight responses and cancels a pending ATOP writeback (memory keeps old word).
//  - FSM IDLE: mem_gnt_o=1. Handshake classes by atop[5:4] and we:
//      atop[5:4]==00, we=1: bytes with strb=1 written at the grant edge; response rdata='0.
//      atop[5:4]==00, we=0: word read at grant edge; response rdata=stored word.
//      atop[5:4]!=00 (any we): old word captured at grant edge, FSM -> AMO_WB.
//  - FSM AMO_WB (exactly one cycle): mem_gnt_o=0; result written under strb at end of the
//    cycle; FSM -> IDLE. Response rdata = old word (also for AtomicStore).
//  - ATOP ops, atop[2:0] for AtomicStore(01)/AtomicLoad(10), on full DataWidth word,
//    operands old word A, wdata B: 000 ADD A+B (mod 2^DataWidth), 001 CLR A&~B, 010 EOR A^B,
//    011 SET A|B, 100 SMAX, 101 SMIN (two's complement), 110 UMAX, 111 UMIN. atop[3] ignored.
//    11_0000 Swap: result B. 11_0001 Compare: unsupported -> no write, rdata = old word.
//  - Latency: mem_rvalid_o rises exactly Latency cycles after the grant edge, for every
//    class (ATOPs too). Responses strictly in grant order; at most one per cycle; back-to-back
//    plain requests give back-to-back responses. Pipeline depth Latency, no stalls.
//  - Ordering: a read granted the cycle after a write/ATOP writeback to the same word returns
//    the new data. A request arriving while in AMO_WB waits (gnt=0); req may stay high and
//    payload must stay stable (stream rule: req not withdrawn before gnt).
//  - Max throughput: 1 plain op/cycle; ATOP costs 2 cycles.
//  - busy-free: no FIFO full/empty conditions; rvalid is never stalled, consumer must sink it.
// TESTING
//  1 Write addr 0x10 wdata 0xDEADBEEF strb 0xF, next cycle read 0x10 -> rvalid 1 cycle after
//    read grant (Latency=1), rdata 0xDEADBEEF; write response rdata 0x0.
//  2 Strobed write 0x10 wdata 0x11223344 strb 0b0101 over 0xDEADBEEF -> read 0xDE22BE44.
//  3 Word=5, AtomicLoad ADD (atop 0x20) B=3 -> rdata 5, gnt low next cycle, later read 8;
//    word=0xFFFFFFFF ADD 1 -> read 0x0 (wrap).
//  4 Word=0xFFFFFFFE: SMAX B=1 -> stores 1; UMAX B=1 -> stores 0xFFFFFFFE; Swap B=7 -> rdata
//    old, stores 7; Compare -> word unchanged.
//  5 Latency=3, 8 back-to-back reads with req held high -> 8 rvalid pulses on consecutive
//    cycles starting 3 cycles after first grant, data in order.
//  6 Issue ATOP then assert rst_ni=0 during AMO_WB -> rvalid never fires, gnt=0 in reset,
//    after release word still holds pre-ATOP value, FSM IDLE, gnt=1.

Source files
------------

// File: rtl/mem_bank_atomic_sram.sv
// Single-bank SRAM endpoint with fixed read latency and in-bank AXI5 ATOP read-modify-write.
// One request per cycle; an ATOP holds the bank for one extra writeback cycle.
module mem_bank_atomic_sram #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned NumWords  = 1024,
  parameter int unsigned Latency   = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   mem_req_i,
  output logic                   mem_gnt_o,
  input  logic [AddrWidth-1:0]   mem_addr_i,
  input  logic [DataWidth-1:0]   mem_wdata_i,
  input  logic [DataWidth/8-1:0] mem_strb_i,
  input  logic [5:0]             mem_atop_i,
  input  logic                   mem_we_i,
  output logic                   mem_rvalid_o,
  output logic [DataWidth-1:0]   mem_rdata_o
);
  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned IdxWidth  = $clog2(NumWords);
  localparam int unsigned OffWidth  = $clog2(StrbWidth);

  typedef enum logic [0:0] {StIdle, StAmoWb} state_e;

  state_e               state_q;
  logic [DataWidth-1:0] mem_q [NumWords];
  logic [IdxWidth-1:0]  idx, amo_idx_q;
  logic [DataWidth-1:0] amo_a_q, amo_b_q, amo_res, rsp_data;
  logic [StrbWidth-1:0] amo_strb_q;
  logic [5:0]           amo_atop_q;
  logic                 amo_wr, hs, is_atop;
  logic [Latency-1:0]   vld_q;
  logic [DataWidth-1:0] dat_q [Latency];
  logic                 unused_addr;

  assign idx         = mem_addr_i[OffWidth +: IdxWidth];
  assign unused_addr = ^mem_addr_i;
  // Grant is forced low while reset is asserted, not just after the state register clears.
  assign mem_gnt_o   = (state_q == StIdle) & rst_ni;
  assign hs          = mem_req_i & mem_gnt_o;
  assign is_atop     = (mem_atop_i[5:4] != 2'b00);
  assign rsp_data    = (mem_we_i && !is_atop) ? '0 : mem_q[idx];

  always_comb begin
    amo_res = amo_a_q;
    amo_wr  = 1'b1;
    if (amo_atop_q[5:4] == 2'b11) begin
      // Only Swap is supported; Compare and other encodings leave the word untouched.
      amo_res = amo_b_q;
      amo_wr  = (amo_atop_q[3:0] == 4'b0000);
    end else begin
      case (amo_atop_q[2:0])
        3'b000:  amo_res = amo_a_q + amo_b_q;
        3'b001:  amo_res = amo_a_q & ~amo_b_q;
        3'b010:  amo_res = amo_a_q ^ amo_b_q;
        3'b011:  amo_res = amo_a_q | amo_b_q;
        3'b100:  amo_res = ($signed(amo_a_q) > $signed(amo_b_q)) ? amo_a_q : amo_b_q;
        3'b101:  amo_res = ($signed(amo_a_q) < $signed(amo_b_q)) ? amo_a_q : amo_b_q;
        3'b110:  amo_res = (amo_a_q > amo_b_q) ? amo_a_q : amo_b_q;
        default: amo_res = (amo_a_q < amo_b_q) ? amo_a_q : amo_b_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      amo_idx_q  <= '0;
      amo_a_q    <= '0;
      amo_b_q    <= '0;
      amo_strb_q <= '0;
      amo_atop_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (hs && is_atop) begin
            state_q    <= StAmoWb;
            amo_idx_q  <= idx;
            amo_a_q    <= mem_q[idx];
            amo_b_q    <= mem_wdata_i;
            amo_strb_q <= mem_strb_i;
            amo_atop_q <= mem_atop_i;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Storage is not reset; an async reset during StAmoWb clears state_q and so cancels writeback.
  always_ff @(posedge clk_i) begin
    if (hs && !is_atop && mem_we_i) begin
      for (int unsigned b = 0; b < StrbWidth; b++) begin
        if (mem_strb_i[b]) mem_q[idx][8*b +: 8] <= mem_wdata_i[8*b +: 8];
      end
    end else if (state_q == StAmoWb && amo_wr) begin
      for (int unsigned b = 0; b < StrbWidth; b++) begin
        if (amo_strb_q[b]) mem_q[amo_idx_q][8*b +: 8] <= amo_res[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < Latency; i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= hs;
      if (hs) dat_q[0] <= rsp_data;
      for (int unsigned i = 1; i < Latency; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign mem_rvalid_o = vld_q[Latency-1];
  assign mem_rdata_o  = dat_q[Latency-1];

endmodule

// File: tb/tb_mem_bank_atomic_sram.sv
// Scoreboard bench: two banks (latency 1 and 3) share one request stream; a monitor checks
// each response's data and arrival cycle against a behavioural memory model.
module tb_mem_bank_atomic_sram;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_strb;
  logic [5:0]  mem_atop;
  logic        mem_we;
  logic        gnt1, gnt3, rv1, rv3;
  logic [31:0] rd1, rd3;

  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] ref_mem [1024];

  typedef struct {
    logic [31:0] data;
    int unsigned cyc;
  } exp_t;
  exp_t q1[$];
  exp_t q3[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_bank_atomic_sram #(.Latency(1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .mem_req_i(mem_req), .mem_gnt_o(gnt1),
    .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata), .mem_strb_i(mem_strb),
    .mem_atop_i(mem_atop), .mem_we_i(mem_we), .mem_rvalid_o(rv1), .mem_rdata_o(rd1)
  );

  mem_bank_atomic_sram #(.Latency(3)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .mem_req_i(mem_req), .mem_gnt_o(gnt3),
    .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata), .mem_strb_i(mem_strb),
    .mem_atop_i(mem_atop), .mem_we_i(mem_we), .mem_rvalid_o(rv3), .mem_rdata_o(rd3)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Applies one access to the reference memory and returns the response data it predicts.
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] d,
                                        input logic [3:0] s, input logic we,
                                        input logic [5:0] at);
    int unsigned w = a[11:2];
    logic [31:0] old = ref_mem[w];
    logic [31:0] res;
    bit          wr = 1'b1;
    int          sa = old;
    int          sb = d;
    longint unsigned ua = old;
    longint unsigned ub = d;
    if (at[5:4] == 2'b00) begin
      if (!we) return old;
      res = d;
    end else if (at[5:4] == 2'b11) begin
      res = d;
      wr  = (at[3:0] == 4'd0);
    end else begin
      case (at[2:0])
        3'd0: res = 32'((ua + ub) % 64'h1_0000_0000);
        3'd1: res = old & ~d;
        3'd2: res = old ^ d;
        3'd3: res = old | d;
        3'd4: res = (sa >= sb) ? old : d;
        3'd5: res = (sa <= sb) ? old : d;
        3'd6: res = (ua >= ub) ? old : d;
        default: res = (ua <= ub) ? old : d;
      endcase
    end
    if (wr) for (int b = 0; b < 4; b++) if (s[b]) ref_mem[w][8*b +: 8] = res[8*b +: 8];
    return (at[5:4] == 2'b00) ? 32'h0 : old;
  endfunction

  // Starts at posedge+1 or at a negedge; returns at posedge+1, or for an ATOP at the
  // negedge of the writeback cycle so the next request can be presented while gnt is low.
  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input logic we, input logic [5:0] at, input bit use_exp,
                       input logic [31:0] expv);
    logic [31:0] e;
    int          n = 0;
    mem_req = 1'b1; mem_addr = a; mem_wdata = d; mem_strb = s; mem_we = we; mem_atop = at;
    @(negedge clk);
    while (!gnt1 && n < 4) begin
      @(negedge clk);
      n++;
    end
    if (!gnt1) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout gnt=%b required=1", gnt1);
    end
    e = model(a, d, s, we, at);
    if (use_exp) e = expv;
    q1.push_back('{data: e, cyc: cyc + 1});
    q3.push_back('{data: e, cyc: cyc + 3});
    @(posedge clk);
    #1;
    mem_req = 1'b0;
    if (at[5:4] != 2'b00) begin
      @(negedge clk);
      chk("gnt_in_amo_wb", {31'd0, gnt1}, 32'd0);
    end
  endtask

  task automatic idle(input int n);
    mem_req = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rv1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL rsp_lat1 unexpected rvalid rdata=%h", rd1);
      end else begin
        e = q1.pop_front();
        if (rd1 !== e.data || cyc != e.cyc) begin
          errors++;
          $display("FAIL rsp_lat1 got=%h@%0d want=%h@%0d", rd1, cyc, e.data, e.cyc);
        end
      end
    end
    if (rv3) begin
      checks++;
      if (q3.size() == 0) begin
        errors++;
        $display("FAIL rsp_lat3 unexpected rvalid rdata=%h", rd3);
      end else begin
        e = q3.pop_front();
        if (rd3 !== e.data || cyc != e.cyc) begin
          errors++;
          $display("FAIL rsp_lat3 got=%h@%0d want=%h@%0d", rd3, cyc, e.data, e.cyc);
        end
      end
    end
  end

  initial begin
    logic [31:0] r, a;
    logic [5:0]  at;
    int unsigned k;
    rst_n = 1'b0; mem_req = 1'b0; mem_addr = '0; mem_wdata = '0;
    mem_strb = '0; mem_atop = '0; mem_we = 1'b0;
    #3;
    chk("reset_gnt", {31'd0, gnt1}, 32'd0);
    chk("reset_rvalid", {30'd0, rv1, rv3}, 32'd0);
    chk("reset_rdata1", rd1, 32'd0);
    chk("reset_rdata3", rd3, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("gnt_after_reset", {30'd0, gnt1, gnt3}, 32'd3);
    @(posedge clk);
    #1;

    // Full write then read, then strobed partial write.
    issue(32'h10, 32'hDEADBEEF, 4'hF, 1'b1, 6'h00, 1'b1, 32'h0);
    issue(32'h10, 32'h0, 4'h0, 1'b0, 6'h00, 1'b1, 32'hDEADBEEF);
    issue(32'h10, 32'h11223344, 4'b0101, 1'b1, 6'h00, 1'b1, 32'h0);
    issue(32'h10, 32'h0, 4'h0, 1'b0, 6'h00, 1'b1, 32'hDE22BE44);

    // ATOP ADD, including wrap-around.
    issue(32'h30, 32'd5, 4'hF, 1'b1, 6'h00, 1'b1, 32'h0);
    issue(32'h30, 32'd3, 4'hF, 1'b0, 6'h20, 1'b1, 32'd5);
    issue(32'h30, 32'd0, 4'h0, 1'b0, 6'h00, 1'b1, 32'd8);
    issue(32'h30, 32'hFFFFFFFF, 4'hF, 1'b1, 6'h00, 1'b1, 32'h0);
    issue(32'h30, 32'd1, 4'hF, 1'b0, 6'h20, 1'b1, 32'hFFFFFFFF);
    issue(32'h30, 32'd0, 4'h0, 1'b0, 6'h00, 1'b1, 32'h0);

    // Signed vs unsigned max, Swap, Compare, AtomicStore.
    issue(32'h20, 32'hFFFFFFFE, 4'hF, 1'b1, 6'h00, 1'b1, 32'h0);
    issue(32'h20, 32'd1, 4'hF, 1'b0, 6'h24, 1'b1, 32'hFFFFFFFE);
    issue(32'h20, 32'd0, 4'h0, 1'b0, 6'h00, 1'b1, 32'd1);
    issue(32'h20, 32'hFFFFFFFE, 4'hF, 1'b1, 6'h00, 1'b1, 32'h0);
    issue(32'h20, 32'd1, 4'hF, 1'b0, 6'h26, 1'b1, 32'hFFFFFFFE);
    issue(32'h20, 32'd0, 4'h0, 1'b0, 6'h00, 1'b1, 32'hFFFFFFFE);
    issue(32'h20, 32'd7, 4'hF, 1'b0, 6'h30, 1'b1, 32'hFFFFFFFE);
    issue(32'h20, 32'd0, 4'h0, 1'b0, 6'h00, 1'b1, 32'd7);
    issue(32'h20, 32'h55, 4'hF, 1'b0, 6'h31, 1'b1, 32'd7);
    issue(32'h20, 32'd0, 4'h0, 1'b0, 6'h00, 1'b1, 32'd7);
    issue(32'h20, 32'hF0, 4'hF, 1'b1, 6'h13, 1'b1, 32'd7);
    issue(32'h20, 32'd0, 4'h0, 1'b0, 6'h00, 1'b1, 32'hF7);

    // Initialise the random working set, then eight back-to-back reads.
    for (int w = 0; w < 8; w++) issue(32'(w * 4), $urandom(), 4'hF, 1'b1, 6'h00, 1'b0, 32'h0);
    for (int w = 0; w < 8; w++) issue(32'(w * 4), 32'h0, 4'h0, 1'b0, 6'h00, 1'b0, 32'h0);

    for (int i = 0; i < 300; i++) begin
      r = $urandom();
      a = {r[31:12], 7'd0, 3'($urandom_range(0, 7)), r[1:0]};
      k = $urandom_range(0, 9);
      if (k < 4) at = 6'h00;
      else if (k < 7) at = 6'h00;
      else if (k < 9) at = {($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10, 4'($urandom())};
      else at = ($urandom_range(0, 1) == 0) ? 6'h30 : 6'h31;
      issue(a, $urandom(), 4'($urandom()), (k >= 4 && k < 7) ? 1'b1 : 1'($urandom()), at,
            1'b0, 32'h0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end

    // Reset during the writeback cycle must cancel the writeback and drop the response.
    issue(32'h40, 32'd100, 4'hF, 1'b1, 6'h00, 1'b1, 32'h0);
    idle(6);
    mem_req = 1'b1; mem_addr = 32'h40; mem_wdata = 32'd1; mem_strb = 4'hF;
    mem_we = 1'b0; mem_atop = 6'h20;
    @(negedge clk);
    chk("gnt_before_amo", {31'd0, gnt1}, 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    mem_req = 1'b0;
    #1;
    chk("gnt_in_reset", {30'd0, gnt1, gnt3}, 32'd0);
    chk("rvalid_in_reset", {30'd0, rv1, rv3}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("gnt_after_midreset", {30'd0, gnt1, gnt3}, 32'd3);
    @(posedge clk);
    #1;
    issue(32'h40, 32'd0, 4'h0, 1'b0, 6'h00, 1'b1, 32'd100);

    idle(8);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    chk("q3_drained", 32'(q3.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
